bp_skid_pipe: RTL

- Parametrised successor to the single-register backpressure pipe.
- Chains PIPES stages, each a 2-entry skid buffer, so ready_o comes only from registers: no combinational ready path through the chain, and full throughput is kept under stalls.
- Adds a synchronous flush, an occupancy count and, optionally, stall statistics.
- Used wherever long ready/valid paths between compute tiles need timing closure without losing bandwidth.

---
 rtl/bp_skid_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bp_skid_pipe.sv
// bp_skid_pipe: chain of PIPES two-entry skid stages on a ready/valid link.
// ready_o comes from a flop, so no combinational ready path runs through the chain.
// Throughput stays at one beat per cycle under stalls.
// It also provides a synchronous flush and a registered occupancy count.
// Optional stall statistics are built when BP_SKID_PIPE_STATS_EN is defined;
// that adds the stall_cnt_o port.
//
// Handshake: a beat moves on a side in any cycle where valid && ready are both
// high on that side. Once valid is raised it stays high, with its data held
// stable, until the beat is taken. Stage ready depends only on that stage's
// own skid flop, never on anything downstream in the same cycle.
module bp_skid_pipe #(
  parameter int DATAW = 8,
  parameter int PIPES = 1,
  parameter int CNTW  = 32,
  localparam int OCCW = (PIPES == 0) ? 1 : $clog2(2 * PIPES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [DATAW-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [DATAW-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
`ifdef BP_SKID_PIPE_STATS_EN
  output logic [CNTW-1:0]  stall_cnt_o,
`endif
  output logic [OCCW-1:0]  occupancy_o
);

  // Encoding makes bit0 the main-valid flop and bit1 the skid-valid flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

  if (PIPES == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk_i, rst_i, flush_i};

    // No storage: the link is a plain wire-through.
    assign data_o      = data_i;
    assign valid_o     = valid_i;
    assign ready_o     = ready_i;
    assign occupancy_o = '0;
  end else begin : g_chain
    logic [PIPES-1:0]            main_valid;
    logic [PIPES-1:0]            skid_valid;
    logic [PIPES-1:0]            in_valid;
    logic [PIPES-1:0]            in_ready;
    logic [PIPES-1:0]            out_ready;
    logic [PIPES-1:0]            in_fire;
    logic [PIPES-1:0]            out_fire;
    logic [PIPES-1:0][DATAW-1:0] main_data;
    logic [PIPES-1:0][DATAW-1:0] in_data;
    logic [OCCW-1:0]             occ_q;
    logic                        in_top;
    logic                        out_top;

    for (genvar k = 0; k < PIPES; k++) begin : g_stage
      stage_state_e     state_q;
      logic [DATAW-1:0] main_q;
      logic [DATAW-1:0] skid_q;

      if (k == 0) begin : g_head
        assign in_valid[k] = valid_i;
        assign in_data[k]  = data_i;
      end else begin : g_link
        assign in_valid[k] = main_valid[k-1];
        assign in_data[k]  = main_data[k-1];
      end

      if (k == PIPES - 1) begin : g_tail
        assign out_ready[k] = ready_i;
      end else begin : g_mid
        assign out_ready[k] = in_ready[k+1];
      end

      assign main_valid[k] = state_q[0];
      assign skid_valid[k] = state_q[1];
      assign main_data[k]  = main_q;
      assign in_ready[k]   = ~skid_valid[k];
      assign in_fire[k]    = in_valid[k] & in_ready[k];
      assign out_fire[k]   = main_valid[k] & out_ready[k];

      // Stage FSM: main feeds downstream, skid catches the beat that arrives during a stall.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q <= ST_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else if (flush_i) begin
          state_q <= ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_fire[k]) begin
                main_q  <= in_data[k];
                state_q <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (in_fire[k] && out_fire[k]) begin
                main_q <= in_data[k];
              end else if (in_fire[k]) begin
                skid_q  <= in_data[k];
                state_q <= ST_FULL;
              end else if (out_fire[k]) begin
                state_q <= ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (out_fire[k]) begin
                main_q  <= skid_q;
                state_q <= ST_ONE;
              end
            end
            default: state_q <= ST_EMPTY;
          endcase
        end
      end
    end

    // Reset forces ready low even though the skid flop is already clear.
    assign ready_o     = in_ready[0] & ~rst_i;
    assign valid_o     = main_valid[PIPES-1];
    assign data_o      = main_data[PIPES-1];
    assign in_top      = valid_i & ready_o;
    assign out_top     = valid_o & ready_i;
    assign occupancy_o = occ_q;

    // Occupancy: +1 per accepted beat, -1 per delivered beat; flush empties the chain.
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        occ_q <= '0;
      end else if (in_top && !out_top) begin
        occ_q <= occ_q + OCCW'(1);
      end else if (!in_top && out_top) begin
        occ_q <= occ_q - OCCW'(1);
      end
    end
  end

`ifdef BP_SKID_PIPE_STATS_EN
  logic [CNTW-1:0] stall_cnt_q;

  // Saturating count of cycles where the output is offered but not taken.
  // Only reset clears it; flush leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNTW'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
